atpg_vector_player: RTL and testbench
=====================================

Name: atpg_vector_player

Overview:
- Synthesizable, parametrised pattern engine for ISCAS-style combinational circuits under test (CUT). Sits beside the CUT in the ATPG bench.
- Holds up to DEPTH stimulus/expected/mask triples and applies them one at a time. After a settle interval it captures the CUT response and compares it against the expected value under a don't-care mask.
- Reports pass/fail, the mismatch count and the first failing index. Replaces file-driven, fixed-width vector application with a reusable, width-generic block.

Parameters:
- IN_W, 41, CUT input width (stimulus bits).
- OUT_W, 32, CUT output width (response bits).
- DEPTH, 16, vector memory entries; AW = $clog2(DEPTH) (localparam).
- SETTLE_CYC, 1, cycles between applying a stimulus and sampling the response; legal range >=1.
- CW, 8, fail_count width.
- POLY, 32'h0400_0007, MISR feedback polynomial (used only with MISR_EN); width OUT_W.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- load_we  in  1  write enable for the vector memory; ignored while busy=1.
- load_addr  in  AW  memory write address.
- load_stim  in  IN_W  stimulus word.
- load_exp  in  OUT_W  expected response.
- load_mask  in  OUT_W  don't-care mask; bit=1 excludes that bit from the compare.
- num_vec  in  AW+1  number of vectors to run; sampled on start.
- start  in  1  single-cycle run request; ignored while busy=1.
- dut_in  out  IN_W  registered stimulus driven to the CUT.
- dut_out  in  OUT_W  CUT response.
- busy  out  1  high in APPLY, SETTLE and CAPTURE.
- done  out  1  one-cycle pulse at run end.
- cur_idx  out  AW  index of the vector in flight.
- fail  out  1  sticky; set if any vector mismatched.
- fail_count  out  CW  count of mismatching vectors; saturates at all-ones.
- first_fail_idx  out  AW  index of the first mismatching vector.
- first_fail_valid  out  1  first_fail_idx is meaningful.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all outputs and state go to 0 and the FSM goes to IDLE. Vector memory contents are not reset. Reset mid-run aborts the run immediately with no done pulse.
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE, on start:
  - latch n = min(num_vec, DEPTH);
  - clear fail, fail_count, first_fail_idx and first_fail_valid;
  - set cur_idx = 0;
  - if n = 0, go to DONE; otherwise go to APPLY.
- APPLY (1 cycle): dut_in <= stim[cur_idx]; go to SETTLE.
- SETTLE (SETTLE_CYC cycles): down-counter runs; dut_in is held; go to CAPTURE when the count expires.
- CAPTURE (1 cycle):
  - mism = |((dut_out ^ exp[cur_idx]) & ~mask[cur_idx]);
  - if mism: set fail, increment fail_count (saturating), and load first_fail_idx/first_fail_valid if first_fail_valid was 0;
  - if cur_idx = n-1, go to DONE; otherwise cur_idx++ and go to APPLY.
- DONE (1 cycle): done = 1 and busy = 0; go to IDLE.
- Result hold: result outputs and dut_in hold their values until the next accepted start.
- Latency: one vector costs 2+SETTLE_CYC cycles. done asserts n*(2+SETTLE_CYC)+1 cycles after the start edge, or 1 cycle after it when n = 0.
- Simultaneous events:
  - start coinciding with done (DONE state) is ignored;
  - load_we while busy is dropped;
  - load_we in IDLE or DONE writes immediately, and a start in the same cycle sees the old contents at the written address only if that address is the one read first; the implementation registers the memory write before the APPLY read, so the new data is always used.

Optional Feature:
- Macro: ATPG_PLAYER_MISR_EN.
- When defined:
  - adds output port signature (OUT_W), cleared on reset and on accepted start;
  - each CAPTURE updates sig <= ((sig<<1) ^ (sig[OUT_W-1] ? POLY : 0)) ^ dut_out, with the mask not applied;
  - signature is held after DONE.
- When undefined: no signature port and no MISR logic.

Test Plan:
All scenarios use DEPTH=16, IN_W=41, OUT_W=32, SETTLE_CYC=1, CW=8, with a loopback CUT: dut_out = dut_in[31:0].
- Pass run: load 4 vectors with stim = {9'h0, 32'hA5A5_0000+i}, exp = stim[31:0], mask = 0; start with num_vec=4 -> busy for 12 cycles, done on cycle 13, fail=0, fail_count=0, first_fail_valid=0.
- Detection: same as the pass run but exp[2] ^= 32'h1 and exp[3] ^= 32'h8000_0000 -> fail=1, fail_count=2, first_fail_idx=2, first_fail_valid=1.
- Masking: same corruption as the detection run with mask[2]=32'h1 and mask[3]=32'h8000_0000 -> fail=0, fail_count=0.
- Boundaries:
  - num_vec=0 -> done one cycle after start, dut_in unchanged;
  - num_vec=31 -> exactly 16 vectors applied and cur_idx ends at 15;
  - start and load_we pulsed while busy -> no effect.
- Reset: assert rst_n=0 during SETTLE of vector 1 -> all outputs 0 asynchronously and no done pulse; restart with num_vec=4 -> same result as the pass run (memory retained).
- MISR (ATPG_PLAYER_MISR_EN): two vectors with dut_out=32'h1 each -> signature 32'h1 after the first CAPTURE, 32'h3 at done.

Source files
------------

// File: rtl/atpg_vector_player.sv
// Vector memory + apply/settle/capture sequencer for a combinational CUT, with masked compare.
// Define ATPG_PLAYER_MISR_EN to add a MISR signature over the raw CUT responses.
module atpg_vector_player #(
  parameter int IN_W       = 41,
  parameter int OUT_W      = 32,
  parameter int DEPTH      = 16,
  parameter int SETTLE_CYC = 1,
  parameter int CW         = 8
`ifdef ATPG_PLAYER_MISR_EN
  ,
  parameter logic [OUT_W-1:0] POLY = 32'h0400_0007
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [IN_W-1:0]          load_stim,
  input  logic [OUT_W-1:0]         load_exp,
  input  logic [OUT_W-1:0]         load_mask,
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     start,
  output logic [IN_W-1:0]          dut_in,
  input  logic [OUT_W-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                     fail,
  output logic [CW-1:0]            fail_count,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic                     first_fail_valid
`ifdef ATPG_PLAYER_MISR_EN
  ,
  output logic [OUT_W-1:0]         signature
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [IN_W-1:0]  r_stim_mem [DEPTH];
  logic [OUT_W-1:0] r_exp_mem  [DEPTH];
  logic [OUT_W-1:0] r_mask_mem [DEPTH];

  logic [AW:0]       r_n;
  logic [AW-1:0]     r_idx;
  logic [SW-1:0]     r_cnt;
  logic [IN_W-1:0]   r_dut_in;
  logic              r_fail;
  logic [CW-1:0]     r_fail_count;
  logic [AW-1:0]     r_ffi;
  logic              r_ffv;

  logic              w_busy;
  logic              w_last;
  logic              w_mism;
  logic [AW:0]       w_n_req;

  assign w_busy  = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign w_last  = (({1'b0, r_idx}) + (AW+1)'(1)) == r_n;
  assign w_mism  = |((dut_out ^ r_exp_mem[r_idx]) & ~r_mask_mem[r_idx]);
  assign w_n_req = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;

  // Writes land at the clock edge before any APPLY read, so a same-cycle start sees new data.
  always_ff @(posedge clk) begin
    if (load_we && !w_busy) begin
      r_stim_mem[load_addr] <= load_stim;
      r_exp_mem[load_addr]  <= load_exp;
      r_mask_mem[load_addr] <= load_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = (num_vec == '0) ? S_DONE : S_APPLY;
      S_APPLY:   w_state_nxt = S_SETTLE;
      S_SETTLE:  if (r_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_last ? S_DONE : S_APPLY;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n          <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_dut_in     <= '0;
      r_fail       <= 1'b0;
      r_fail_count <= '0;
      r_ffi        <= '0;
      r_ffv        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n          <= w_n_req;
            r_idx        <= '0;
            r_fail       <= 1'b0;
            r_fail_count <= '0;
            r_ffi        <= '0;
            r_ffv        <= 1'b0;
          end
        end
        S_APPLY: begin
          r_dut_in <= r_stim_mem[r_idx];
          r_cnt    <= SW'(SETTLE_CYC - 1);
        end
        S_SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - SW'(1);
        end
        S_CAPTURE: begin
          if (w_mism) begin
            r_fail <= 1'b1;
            if (r_fail_count != '1) r_fail_count <= r_fail_count + CW'(1);
            if (!r_ffv) begin
              r_ffi <= r_idx;
              r_ffv <= 1'b1;
            end
          end
          // Index stays on the last vector so cur_idx reports where the run ended.
          if (!w_last) r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ATPG_PLAYER_MISR_EN
  logic [OUT_W-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_sig <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_sig <= ((r_sig << 1) ^ (r_sig[OUT_W-1] ? POLY : '0)) ^ dut_out;
    end
  end

  assign signature = r_sig;
`endif

  assign dut_in           = r_dut_in;
  assign busy             = w_busy;
  assign done             = (r_state == S_DONE);
  assign cur_idx          = r_idx;
  assign fail             = r_fail;
  assign fail_count       = r_fail_count;
  assign first_fail_idx   = r_ffi;
  assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_atpg_vector_player.sv
// Directed bench for atpg_vector_player with a loopback CUT (dut_out = dut_in[31:0]).
module tb_atpg_vector_player;

  localparam int IN_W = 41;
  localparam int OUT_W = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int CW = 8;

  logic              clk;
  logic              rst_n;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [IN_W-1:0]   load_stim;
  logic [OUT_W-1:0]  load_exp;
  logic [OUT_W-1:0]  load_mask;
  logic [AW:0]       num_vec;
  logic              start;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     cur_idx;
  logic              fail;
  logic [CW-1:0]     fail_count;
  logic [AW-1:0]     first_fail_idx;
  logic              first_fail_valid;
`ifdef ATPG_PLAYER_MISR_EN
  logic [OUT_W-1:0]  signature;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  assign dut_out = dut_in[31:0];

  atpg_vector_player #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE_CYC(1), .CW(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .num_vec(num_vec), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .cur_idx(cur_idx), .fail(fail),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
`ifdef ATPG_PLAYER_MISR_EN
    , .signature(signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] stim_of(input int i);
    return {9'h0, 32'(32'hA5A5_0000 + i)};
  endfunction

  task automatic load_vec(input int addr, input logic [IN_W-1:0] s,
                          input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
    @(negedge clk);
    load_we = 1'b1; load_addr = AW'(addr); load_stim = s; load_exp = e; load_mask = m;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Starts a run, samples each cycle after the start edge; cycle 1 is the first sample.
  task automatic run_vec(input int num, input bit inject, output int done_cyc, output int busy_cyc);
    int cyc;
    @(negedge clk);
    num_vec = (AW+1)'(num); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cyc = -1; busy_cyc = 0;
    while (cyc <= 200) begin
      if (inject && cyc == 3) begin
        start = 1'b1; load_we = 1'b1; load_addr = '0;
        load_stim = '1; load_exp = 32'hDEAD_BEEF; load_mask = '0;
      end else if (inject && cyc == 4) begin
        start = 1'b0; load_we = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    if (done_cyc < 0) check("run_timeout", 64'd0, 64'd1);
    if (inject) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", busy, 1'b0);
    end
  endtask

  int dc, bc;
  bit saw_done;

  initial begin
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_stim = '0;
    load_exp = '0; load_mask = '0; num_vec = '0; start = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_results", {fail, fail_count, first_fail_idx, first_fail_valid, cur_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load_vec(i, stim_of(i), stim_of(i)[31:0], '0);

    // Pass run
    run_vec(4, 0, dc, bc);
    check("pass_done_cyc", dc, 13);
    check("pass_busy_cyc", bc, 12);
    check("pass_fail", fail, 0);
    check("pass_fail_count", fail_count, 0);
    check("pass_ffv", first_fail_valid, 0);
    check("pass_cur_idx", cur_idx, 3);
    check("pass_dut_in", dut_in, stim_of(3));
    @(negedge clk);
    check("pass_hold_dut_in", dut_in, stim_of(3));

    // Detection
    load_vec(2, stim_of(2), 32'hA5A5_0002 ^ 32'h1, '0);
    load_vec(3, stim_of(3), 32'hA5A5_0003 ^ 32'h8000_0000, '0);
    run_vec(4, 0, dc, bc);
    check("det_fail", fail, 1);
    check("det_fail_count", fail_count, 2);
    check("det_ffi", first_fail_idx, 2);
    check("det_ffv", first_fail_valid, 1);

    // Zero-length run clears results and leaves dut_in alone
    run_vec(0, 0, dc, bc);
    check("zero_done_cyc", dc, 1);
    check("zero_busy_cyc", bc, 0);
    check("zero_dut_in", dut_in, stim_of(3));
    check("zero_cleared", {fail, fail_count, first_fail_valid}, 0);

    // Masking
    load_vec(2, stim_of(2), 32'hA5A5_0002 ^ 32'h1, 32'h1);
    load_vec(3, stim_of(3), 32'hA5A5_0003 ^ 32'h8000_0000, 32'h8000_0000);
    run_vec(4, 0, dc, bc);
    check("mask_fail", fail, 0);
    check("mask_fail_count", fail_count, 0);
    check("mask_ffv", first_fail_valid, 0);

    load_vec(2, stim_of(2), stim_of(2)[31:0], '0);
    load_vec(3, stim_of(3), stim_of(3)[31:0], '0);

    // num_vec beyond DEPTH clamps to 16
    run_vec(31, 0, dc, bc);
    check("clamp_done_cyc", dc, 49);
    check("clamp_busy_cyc", bc, 48);
    check("clamp_cur_idx", cur_idx, 15);
    check("clamp_dut_in", dut_in, stim_of(15));
    check("clamp_fail", fail, 0);

    // start/load_we while busy dropped
    run_vec(4, 1, dc, bc);
    check("busy_inj_done_cyc", dc, 13);
    check("busy_inj_fail", fail, 0);
    run_vec(1, 0, dc, bc);
    check("busy_inj_mem_kept", fail, 0);
    check("busy_inj_mem_dut_in", dut_in, stim_of(0));

    // Asynchronous reset during SETTLE of vector 1
    @(negedge clk);
    num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_idx", cur_idx, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          {busy, done, dut_in, cur_idx, fail, fail_count, first_fail_idx, first_fail_valid}, 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("rst_no_done", saw_done, 0);
    rst_n = 1'b1;
    run_vec(4, 0, dc, bc);
    check("rerun_done_cyc", dc, 13);
    check("rerun_fail", {fail, fail_count, first_fail_valid}, 0);
    check("rerun_dut_in", dut_in, stim_of(3));

`ifdef ATPG_PLAYER_MISR_EN
    load_vec(0, 41'h1, 32'h1, '0);
    load_vec(1, 41'h1, 32'h1, '0);
    @(negedge clk);
    num_vec = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("misr_cleared", signature, 0);
    repeat (3) @(negedge clk);
    check("misr_first", signature, 32'h1);
    repeat (3) @(negedge clk);
    check("misr_done_seen", done, 1);
    check("misr_final", signature, 32'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
